key_event_queue: RTL
====================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter NUM_JOY, default 2: number of gamepad channels merged into the numeric-key path.
REQ-002 Parameter DEPTH, default 8: event FIFO depth; power of two, at least 2.
REQ-003 clk_sys  in  1  system clock; all logic on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 ps2_key  in  11  [10] toggles once per key event, [9] 1=pressed, [8] extended flag, [7:0] scan code.
REQ-006 joy_numpad  in  NUM_JOY*10  channel c occupies bits [c*10+9:c*10]; bit k=1 means key held; k=0..8 -> "1".."9", k=9 -> "0".
REQ-007 evt_valid  out  1  FIFO head holds an event.
REQ-008 evt_ascii  out  8  ASCII code at the FIFO head.
REQ-009 evt_released  out  1  FIFO head is a release (1) or a press (0).
REQ-010 evt_ack  in  1  consumer pop strobe, one event per cycle.
REQ-011 overflow  out  1  sticky flag: a PS/2 event was lost.
REQ-012 clear_overflow  in  1  synchronous clear of overflow.
REQ-013 fill_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 PS/2 detect: ps2_key[10] is compared with a registered copy; any mismatch is one event; ps2_key[8] is ignored.
REQ-015 Translation (scan code -> ASCII): 16/1E/26/25/2E/36/3D/3E/46/45 -> "1".."9","0"; the 26 letter codes map to "a".."z"; 29 -> " ", 79 -> "+", 7B -> "-", 7C -> "*", 4A -> "/", 55 -> "=", 1F -> 0x11, 27 -> 0x12, 5A -> 0x0A, 66 -> 0x08.
REQ-016 Unmapped scan codes produce no event and do not set overflow.
REQ-017 A translated PS/2 event is loaded into a single-entry pending register holding {released = ~ps2_key[9], ascii}.
REQ-018 If the pending register is still occupied when a new PS/2 event arrives, the new event overwrites it and overflow sets.
REQ-019 Gamepad path: the channels are ORed per key into a 10-bit held vector, registered once.
REQ-020 A 10-bit emitted_state records the last state queued per key; key k needs an event whenever held[k] != emitted_state[k].
REQ-021 Press/release sequences shorter than a queue stall coalesce; the final queued state always equals the held state, so no key sticks.
REQ-022 A key stays held while any channel holds it; a release is queued only when all channels have released it.
REQ-023 Arbiter: at most one FIFO write per cycle; the PS/2 pending entry has priority; otherwise the lowest k with a mismatch wins.
REQ-024 On a gamepad write, emitted_state[k] updates in the same cycle as the write.
REQ-025 Latency, empty FIFO, no contention: evt_valid rises after the 2nd rising edge following a ps2_key[10] or joy_numpad change.
REQ-026 FIFO is first-word fall-through: evt_ascii and evt_released show the head while evt_valid=1, and are 0 while evt_valid=0.
REQ-027 evt_ack with evt_valid=1 pops one entry; evt_ack while empty is ignored.
REQ-028 Full FIFO: no write, so PS/2 and gamepad events wait pending; a write is allowed when full if evt_ack pops in the same cycle.
REQ-029 Simultaneous push and pop leave fill_level unchanged; read and write pointers wrap modulo DEPTH.
REQ-030 clear_overflow clears overflow; if an overflow occurs in the same cycle, set wins.

Reset
REQ-031 On reset: FIFO empty, fill_level=0, evt_valid=0, evt_ascii=0, evt_released=0, overflow=0, emitted_state=0, PS/2 pending cleared.
REQ-032 On the first clock edge after reset deasserts, the PS/2 toggle copy loads from ps2_key[10] and no event is generated.
REQ-033 Gamepad keys held at reset release generate press events normally.
REQ-034 Reset asserted mid-operation discards all queued and pending events immediately.

Verification
REQ-035 Toggle ps2_key with code 1C, [9]=1 -> 2 edges later evt_valid=1, evt_ascii=0x61, evt_released=0; evt_ack -> evt_valid=0.
REQ-036 Channel 1 presses key 4, then channel 0 presses key 4, then channel 1 releases it -> one "5" press queued and no release; channel 0 release -> "5" release queued.
REQ-037 Fill all DEPTH=8 entries with no ack, then one more PS/2 event (pending), then another -> overflow=1; after ack, the second event is dequeued last; clear_overflow -> overflow=0.
REQ-038 FIFO full, gamepad key 0 pressed and released before any ack -> no "1" events queued; fill_level stays 8.
REQ-039 PS/2 event and gamepad key 2 change in the same cycle -> PS/2 event queued first, "3" the next cycle.
REQ-040 Hold ps2_key[10]=1 through reset release -> no event; subsequent toggle -> exactly one event.

Source files
------------

// File: rtl/key_event_queue.sv
// Merges PS/2 keyboard events and gamepad numeric keys into a small
// first-word-fall-through queue of {released, ascii} key events.
module key_event_queue #(
    parameter int unsigned NUM_JOY = 2,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [10:0]                ps2_key,
    input  logic [NUM_JOY*10-1:0]      joy_numpad,
    output logic                       evt_valid,
    output logic [7:0]                 evt_ascii,
    output logic                       evt_released,
    input  logic                       evt_ack,
    output logic                       overflow,
    input  logic                       clear_overflow,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 9;

    // The extended flag plays no part in translation.
    logic ps2_ext_unused;
    assign ps2_ext_unused = ps2_key[8];

    // Scan code to ASCII translation.
    logic       xl_hit;
    logic [7:0] xl_ascii;

    always_comb begin
        xl_hit   = 1'b1;
        xl_ascii = 8'h00;
        case (ps2_key[7:0])
            8'h16: xl_ascii = 8'h31;
            8'h1E: xl_ascii = 8'h32;
            8'h26: xl_ascii = 8'h33;
            8'h25: xl_ascii = 8'h34;
            8'h2E: xl_ascii = 8'h35;
            8'h36: xl_ascii = 8'h36;
            8'h3D: xl_ascii = 8'h37;
            8'h3E: xl_ascii = 8'h38;
            8'h46: xl_ascii = 8'h39;
            8'h45: xl_ascii = 8'h30;
            8'h1C: xl_ascii = 8'h61;
            8'h32: xl_ascii = 8'h62;
            8'h21: xl_ascii = 8'h63;
            8'h23: xl_ascii = 8'h64;
            8'h24: xl_ascii = 8'h65;
            8'h2B: xl_ascii = 8'h66;
            8'h34: xl_ascii = 8'h67;
            8'h33: xl_ascii = 8'h68;
            8'h43: xl_ascii = 8'h69;
            8'h3B: xl_ascii = 8'h6A;
            8'h42: xl_ascii = 8'h6B;
            8'h4B: xl_ascii = 8'h6C;
            8'h3A: xl_ascii = 8'h6D;
            8'h31: xl_ascii = 8'h6E;
            8'h44: xl_ascii = 8'h6F;
            8'h4D: xl_ascii = 8'h70;
            8'h15: xl_ascii = 8'h71;
            8'h2D: xl_ascii = 8'h72;
            8'h1B: xl_ascii = 8'h73;
            8'h2C: xl_ascii = 8'h74;
            8'h3C: xl_ascii = 8'h75;
            8'h2A: xl_ascii = 8'h76;
            8'h1D: xl_ascii = 8'h77;
            8'h22: xl_ascii = 8'h78;
            8'h35: xl_ascii = 8'h79;
            8'h1A: xl_ascii = 8'h7A;
            8'h29: xl_ascii = 8'h20;
            8'h79: xl_ascii = 8'h2B;
            8'h7B: xl_ascii = 8'h2D;
            8'h7C: xl_ascii = 8'h2A;
            8'h4A: xl_ascii = 8'h2F;
            8'h55: xl_ascii = 8'h3D;
            8'h1F: xl_ascii = 8'h11;
            8'h27: xl_ascii = 8'h12;
            8'h5A: xl_ascii = 8'h0A;
            8'h66: xl_ascii = 8'h08;
            default: xl_hit = 1'b0;
        endcase
    end

    // State registers.
    logic           armed;
    logic           tog_q;
    logic           pend_valid;
    logic           pend_released;
    logic [7:0]     pend_ascii;
    logic [9:0]     held;
    logic [9:0]     emitted_state;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [EW-1:0]  mem [DEPTH];

    // Gamepad channels merged per key.
    logic [9:0] held_c;

    always_comb begin
        held_c = '0;
        for (int c = 0; c < int'(NUM_JOY); c++) begin
            held_c = held_c | joy_numpad[c*10 +: 10];
        end
    end

    // Lowest-numbered key whose held state differs from the last queued state.
    logic [9:0] mismatch;
    logic [3:0] joy_sel;

    assign mismatch = held ^ emitted_state;

    always_comb begin
        joy_sel = '0;
        for (int k = 9; k >= 0; k--) begin
            if (mismatch[k]) begin
                joy_sel = 4'(k);
            end
        end
    end

    logic [7:0] joy_ascii;
    assign joy_ascii = (joy_sel == 4'd9) ? 8'h30 : 8'(8'h31 + 8'(joy_sel));

    // Write arbitration: pending PS/2 entry first, then gamepad.
    logic           ps2_evt;
    logic           pop;
    logic           can_write;
    logic           wr_pend;
    logic           wr_joy;
    logic           wr_en;
    logic [EW-1:0]  wdata;
    logic [AW-1:0]  rd_next;
    logic [CW-1:0]  cnt_next;
    logic [EW-1:0]  head_next;

    assign ps2_evt   = armed & (ps2_key[10] != tog_q) & xl_hit;
    assign pop       = evt_ack & evt_valid;
    assign can_write = (fill_level != CW'(DEPTH)) | pop;
    assign wr_pend   = can_write & pend_valid;
    assign wr_joy    = can_write & ~pend_valid & (|mismatch);
    assign wr_en     = wr_pend | wr_joy;
    assign wdata     = wr_pend ? {pend_released, pend_ascii}
                               : {~held[joy_sel], joy_ascii};
    assign rd_next   = pop ? AW'(rd_ptr + AW'(1)) : rd_ptr;
    assign cnt_next  = CW'(fill_level + CW'(wr_en) - CW'(pop));

    // Next head value, bypassing the array when the head is written this cycle.
    always_comb begin
        head_next = '0;
        if (cnt_next != '0) begin
            head_next = (wr_en && (rd_next == wr_ptr)) ? wdata : mem[rd_next];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            armed         <= 1'b0;
            tog_q         <= 1'b0;
            pend_valid    <= 1'b0;
            pend_released <= 1'b0;
            pend_ascii    <= '0;
            held          <= '0;
            emitted_state <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fill_level    <= '0;
            evt_valid     <= 1'b0;
            evt_ascii     <= '0;
            evt_released  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            armed <= 1'b1;
            tog_q <= ps2_key[10];
            held  <= held_c;

            if (ps2_evt) begin
                pend_valid    <= 1'b1;
                pend_released <= ~ps2_key[9];
                pend_ascii    <= xl_ascii;
            end else if (wr_pend) begin
                pend_valid <= 1'b0;
            end

            if (wr_joy) begin
                emitted_state[joy_sel] <= held[joy_sel];
            end

            if (wr_en) begin
                wr_ptr <= AW'(wr_ptr + AW'(1));
            end
            rd_ptr     <= rd_next;
            fill_level <= cnt_next;

            evt_valid    <= (cnt_next != '0);
            evt_released <= head_next[8];
            evt_ascii    <= head_next[7:0];

            // A lost PS/2 event takes precedence over a clear request.
            if (ps2_evt && pend_valid && !wr_pend) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
